// File: rtl/addsub_share_pkg.sv
// Shared types and constants for the add/sub sharing sequencer.
package addsub_share_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/ripple_adder.sv
// WIDTH-bit ripple-carry adder; the single datapath instance shared by all requesters.
module ripple_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] s_o,
    output logic             cout_o
);

    logic [WIDTH:0] c;

    assign c[0] = cin_i;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
        assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end

    assign cout_o = c[WIDTH];

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after ptr_i, wrapping.
module rr_arbiter #(
    parameter int NREQ = 4,
    localparam int IW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    input  logic            en_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IW-1:0]   idx_o
);

    int   j;
    logic found;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        j       = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr_i) + k;
            if (j >= NREQ) j = j - NREQ;
            if (en_i && !found && req_i[j]) begin
                found      = 1'b1;
                grant_o[j] = 1'b1;
                idx_o      = IW'(j);
            end
        end
    end

endmodule

// File: rtl/addsub_share_ctrl.sv
// Round-robin sequencer sharing one ripple add/sub datapath between NREQ requesters.
// ADDSUB_SHARE_OVF_EN compiles in signed-overflow logic; otherwise RSP_OVF is tied low.
module addsub_share_ctrl
    import addsub_share_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NREQ-1:0]       REQ_VALID,
    input  logic [NREQ-1:0]       REQ_OP,
    input  logic [NREQ*WIDTH-1:0] REQ_A,
    input  logic [NREQ*WIDTH-1:0] REQ_B,
    output logic [NREQ-1:0]       REQ_READY,
    output logic                  RSP_VALID,
    input  logic                  RSP_READY,
    output logic [IW-1:0]         RSP_ID,
    output logic [WIDTH-1:0]      RSP_S,
    output logic                  RSP_COUT,
    output logic                  RSP_OVF
);

    state_e            state_q, state_d;
    logic [IW-1:0]     ptr_q, id_q, rsp_id_q, gnt_idx;
    logic [NREQ-1:0]   gnt;
    logic              arb_en;
    logic [WIDTH-1:0]  a_q, b_q, sum, rsp_s_q, sel_a, sel_b;
    logic              cin_q, cout, rsp_cout_q, sel_op;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req_i   (REQ_VALID),
        .ptr_i   (ptr_q),
        .en_i    (arb_en),
        .grant_o (gnt),
        .idx_o   (gnt_idx)
    );

    assign sel_op = REQ_OP[gnt_idx];
    assign sel_a  = REQ_A[int'(gnt_idx)*WIDTH +: WIDTH];
    assign sel_b  = REQ_B[int'(gnt_idx)*WIDTH +: WIDTH];

    ripple_adder #(.WIDTH(WIDTH)) u_add (
        .a_i    (a_q),
        .b_i    (b_q),
        .cin_i  (cin_q),
        .s_o    (sum),
        .cout_o (cout)
    );

    always_comb begin
        state_d = state_q;
        arb_en  = 1'b0;
        case (state_q)
            IDLE: begin
                arb_en = !RST;
                if (|gnt) state_d = EXEC;
            end
            EXEC:    state_d = RESP;
            RESP:    if (RSP_READY) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // cin_q doubles as the captured opcode: subtract is A + ~B + 1.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            cin_q      <= 1'b0;
            id_q       <= '0;
            rsp_s_q    <= '0;
            rsp_cout_q <= 1'b0;
            rsp_id_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && |gnt) begin
                a_q   <= sel_a;
                b_q   <= (sel_op == OP_SUB) ? ~sel_b : sel_b;
                cin_q <= sel_op;
                id_q  <= gnt_idx;
            end
            if (state_q == EXEC) begin
                rsp_s_q    <= sum;
                rsp_cout_q <= cout;
                rsp_id_q   <= id_q;
            end
            if (state_q == RESP && RSP_READY)
                ptr_q <= (id_q == IW'(NREQ-1)) ? '0 : id_q + IW'(1);
        end
    end

`ifdef ADDSUB_SHARE_OVF_EN
    logic ovf, rsp_ovf_q;

    assign ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);

    always_ff @(posedge CLK) begin
        if (RST)                   rsp_ovf_q <= 1'b0;
        else if (state_q == EXEC)  rsp_ovf_q <= ovf;
    end

    assign RSP_OVF = rsp_ovf_q;
`else
    assign RSP_OVF = 1'b0;
`endif

    assign REQ_READY = gnt;
    assign RSP_VALID = (state_q == RESP);
    assign RSP_ID    = rsp_id_q;
    assign RSP_S     = rsp_s_q;
    assign RSP_COUT  = rsp_cout_q;

endmodule

// File: tb/tb_addsub_share_ctrl.sv
// Directed self-checking bench for addsub_share_ctrl (WIDTH=8, NREQ=4).
module tb_addsub_share_ctrl;

    localparam int W = 8;
    localparam int N = 4;

`ifdef ADDSUB_SHARE_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic           CLK = 1'b0;
    logic           RST;
    logic [N-1:0]   REQ_VALID, REQ_OP, REQ_READY;
    logic [N*W-1:0] REQ_A, REQ_B;
    logic           RSP_VALID, RSP_READY, RSP_COUT, RSP_OVF;
    logic [1:0]     RSP_ID;
    logic [W-1:0]   RSP_S;

    int checks = 0;
    int errors = 0;

    addsub_share_ctrl #(.WIDTH(W), .NREQ(N)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .REQ_VALID (REQ_VALID),
        .REQ_OP    (REQ_OP),
        .REQ_A     (REQ_A),
        .REQ_B     (REQ_B),
        .REQ_READY (REQ_READY),
        .RSP_VALID (RSP_VALID),
        .RSP_READY (RSP_READY),
        .RSP_ID    (RSP_ID),
        .RSP_S     (RSP_S),
        .RSP_COUT  (RSP_COUT),
        .RSP_OVF   (RSP_OVF)
    );

    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic set_req(input int idx, input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
        REQ_VALID[idx]      = 1'b1;
        REQ_OP[idx]         = op;
        REQ_A[idx*W +: W]   = a;
        REQ_B[idx*W +: W]   = b;
    endtask

    task automatic do_reset;
        RST       = 1'b1;
        REQ_VALID = '0;
        tick;
        tick;
        RST = 1'b0;
    endtask

    task automatic test_reset;
        RST       = 1'b1;
        REQ_VALID = '1;
        tick;
        @(negedge CLK);
        checks++; if (REQ_READY !== 4'b0000) begin errors++; $display("FAIL rst_ready got %b want 0000", REQ_READY); end
        checks++; if (RSP_VALID !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", RSP_VALID); end
        checks++; if (RSP_S !== 8'h00) begin errors++; $display("FAIL rst_s got %h want 00", RSP_S); end
        checks++; if (RSP_ID !== 2'd0) begin errors++; $display("FAIL rst_id got %0d want 0", RSP_ID); end
        checks++; if (RSP_COUT !== 1'b0) begin errors++; $display("FAIL rst_cout got %b want 0", RSP_COUT); end
        checks++; if (RSP_OVF !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b want 0", RSP_OVF); end
        tick;
        REQ_VALID = '0;
        RST       = 1'b0;
    endtask

    // One isolated request from idle; RSP_READY is high so the response retires at t+2.
    task automatic single_op(input string nm, input int idx, input logic op, input logic [W-1:0] a,
                             input logic [W-1:0] b, input logic [W-1:0] es, input logic ec, input logic eo);
        logic [N-1:0] er;
        er      = '0;
        er[idx] = 1'b1;
        set_req(idx, op, a, b);
        @(negedge CLK);
        checks++; if (REQ_READY !== er) begin errors++; $display("FAIL %s_ready got %b want %b", nm, REQ_READY, er); end
        tick;
        REQ_VALID[idx] = 1'b0;
        @(negedge CLK);
        checks++; if (RSP_VALID !== 1'b0) begin errors++; $display("FAIL %s_exec_valid got %b want 0", nm, RSP_VALID); end
        tick;
        @(negedge CLK);
        checks++; if (RSP_VALID !== 1'b1) begin errors++; $display("FAIL %s_valid got %b want 1", nm, RSP_VALID); end
        checks++; if (RSP_ID !== 2'(idx)) begin errors++; $display("FAIL %s_id got %0d want %0d", nm, RSP_ID, idx); end
        checks++; if (RSP_S !== es) begin errors++; $display("FAIL %s_s got %h want %h", nm, RSP_S, es); end
        checks++; if (RSP_COUT !== ec) begin errors++; $display("FAIL %s_cout got %b want %b", nm, RSP_COUT, ec); end
        checks++; if (RSP_OVF !== (eo & OVF_ON)) begin errors++; $display("FAIL %s_ovf got %b want %b", nm, RSP_OVF, eo & OVF_ON); end
        tick;
    endtask

    task automatic test_add_ovf;
        single_op("add_ovf", 1, 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
    endtask

    task automatic test_sub;
        single_op("sub_borrow", 2, 1'b1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0);
        single_op("sub_noborrow", 2, 1'b1, 8'h07, 8'h05, 8'h02, 1'b1, 1'b0);
    endtask

    task automatic test_wrap;
        single_op("add_wrap", 0, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
    endtask

    // All four requesters held valid: grants 0,1,2,3,0 every third cycle.
    task automatic test_round_robin;
        logic [N-1:0] er;
        int           id;
        do_reset;
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 8'(i), 8'h10);
        for (int cyc = 0; cyc <= 12; cyc++) begin
            id = (cyc / 3) % N;
            er = '0;
            if (cyc % 3 == 0) er[id] = 1'b1;
            @(negedge CLK);
            checks++; if (REQ_READY !== er) begin errors++; $display("FAIL rr_ready cyc%0d got %b want %b", cyc, REQ_READY, er); end
            if (cyc % 3 == 2) begin
                checks++; if (RSP_VALID !== 1'b1 || RSP_ID !== 2'(id) || RSP_S !== 8'(id + 16)) begin
                    errors++; $display("FAIL rr_rsp cyc%0d got v%b id%0d s%h want v1 id%0d s%h", cyc, RSP_VALID, RSP_ID, RSP_S, id, 8'(id + 16));
                end
            end
            tick;
        end
        REQ_VALID = '0;
        tick;
        tick;
    endtask

    // Response held for 5 stalled cycles; a newcomer must wait until the handshake.
    task automatic test_stall;
        set_req(0, 1'b0, 8'h12, 8'h34);
        RSP_READY = 1'b0;
        @(negedge CLK);
        checks++; if (REQ_READY !== 4'b0001) begin errors++; $display("FAIL stall_ready got %b want 0001", REQ_READY); end
        tick;
        REQ_VALID[0] = 1'b0;
        set_req(2, 1'b1, 8'h09, 8'h03);
        @(negedge CLK);
        checks++; if (REQ_READY !== 4'b0000) begin errors++; $display("FAIL stall_exec_ready got %b want 0000", REQ_READY); end
        tick;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            checks++; if (RSP_VALID !== 1'b1 || RSP_S !== 8'h46 || RSP_ID !== 2'd0 || REQ_READY !== 4'b0000) begin
                errors++; $display("FAIL stall_hold k%0d got v%b s%h id%0d rdy%b want v1 s46 id0 rdy0000", k, RSP_VALID, RSP_S, RSP_ID, REQ_READY);
            end
            tick;
        end
        RSP_READY = 1'b1;
        @(negedge CLK);
        checks++; if (RSP_VALID !== 1'b1 || RSP_S !== 8'h46) begin errors++; $display("FAIL stall_release got v%b s%h want v1 s46", RSP_VALID, RSP_S); end
        tick;
        @(negedge CLK);
        checks++; if (REQ_READY !== 4'b0100) begin errors++; $display("FAIL stall_next_ready got %b want 0100", REQ_READY); end
        tick;
        REQ_VALID = '0;
        tick;
        @(negedge CLK);
        checks++; if (RSP_VALID !== 1'b1 || RSP_S !== 8'h06 || RSP_ID !== 2'd2 || RSP_COUT !== 1'b1) begin
            errors++; $display("FAIL stall_next_rsp got v%b s%h id%0d c%b want v1 s06 id2 c1", RSP_VALID, RSP_S, RSP_ID, RSP_COUT);
        end
        tick;
    endtask

    // Reset during EXEC drops the in-flight op; requester 3 then wins with 0..2 idle.
    task automatic test_reset_mid;
        set_req(1, 1'b0, 8'h20, 8'h22);
        @(negedge CLK);
        checks++; if (REQ_READY !== 4'b0010) begin errors++; $display("FAIL rmid_ready got %b want 0010", REQ_READY); end
        tick;
        REQ_VALID = '0;
        set_req(3, 1'b0, 8'h01, 8'h02);
        RST = 1'b1;
        @(negedge CLK);
        checks++; if (REQ_READY !== 4'b0000) begin errors++; $display("FAIL rmid_rst_ready got %b want 0000", REQ_READY); end
        tick;
        RST = 1'b0;
        @(negedge CLK);
        checks++; if (RSP_VALID !== 1'b0 || RSP_S !== 8'h00) begin errors++; $display("FAIL rmid_norsp got v%b s%h want v0 s00", RSP_VALID, RSP_S); end
        checks++; if (REQ_READY !== 4'b1000) begin errors++; $display("FAIL rmid_grant got %b want 1000", REQ_READY); end
        tick;
        REQ_VALID = '0;
        @(negedge CLK);
        checks++; if (RSP_VALID !== 1'b0) begin errors++; $display("FAIL rmid_exec_valid got %b want 0", RSP_VALID); end
        tick;
        @(negedge CLK);
        checks++; if (RSP_VALID !== 1'b1 || RSP_ID !== 2'd3 || RSP_S !== 8'h03) begin
            errors++; $display("FAIL rmid_rsp got v%b id%0d s%h want v1 id3 s03", RSP_VALID, RSP_ID, RSP_S);
        end
        tick;
    endtask

    initial begin
        RST       = 1'b1;
        REQ_VALID = '0;
        REQ_OP    = '0;
        REQ_A     = '0;
        REQ_B     = '0;
        RSP_READY = 1'b1;
        test_reset;
        test_add_ovf;
        test_sub;
        test_wrap;
        test_round_robin;
        test_stall;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
